// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from a framed stream,
// writes them to instruction RAM and holds the core in reset until the image verifies.
module imem_loader #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);
  localparam int         TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit         TMO_EN  = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  localparam logic [8:0] DEPTH9  = 9'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d, ww_q, ww_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [7:0]          csum_q, csum_d;
  logic [TW-1:0]       tmo_q, tmo_d, tmo_inc;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [1:0]          err_q, err_d;
  logic                core_reset_q, done_q, error_q;
  logic                accept, listening, timed_out;

  assign listening = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = listening && rx_valid;
  assign tmo_inc   = tmo_q + TW'(1);
  assign timed_out = TMO_EN && listening && !accept && (tmo_inc == TMO_LIM);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ww_d      = ww_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    csum_d    = csum_q;
    tmo_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    // Idle-gap counter only runs while the loader is waiting on the host.
    if (listening && !accept && TMO_EN) tmo_d = tmo_inc;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          ww_d    = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          err_d   = 2'b00;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH9) begin
            state_d = S_ERR;
            err_d   = 2'b01;
          end else begin
            n_d     = rx_data[ADDR_W:0];
            state_d = S_DATA;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = 2'b11;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = {shift_q[23:0], rx_data};
          csum_d  = csum_q ^ rx_data;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = ww_q[ADDR_W-1:0];
            wr_data_d = {shift_q[23:0], rx_data};
          end
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = 2'b11;
        end
      end
      S_WRITE: begin
        ww_d    = ww_q + (ADDR_W+1)'(1);
        state_d = (ww_d == n_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) state_d = S_DONE;
          else begin
            state_d = S_ERR;
            err_d   = 2'b10;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      ww_q         <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 2'b00;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      ww_q         <= ww_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
      // Status flops track the next state so they change on the same edge as it.
      core_reset_q <= (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERR);
    end
  end

  assign rx_ready      = listening;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign core_reset    = core_reset_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign words_written = ww_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loading, header/checksum/timeout errors,
// mid-session reset and a full-depth streamed image.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, wr_en, core_reset, done, error;
  logic [5:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0] err_code;
  logic [6:0] words_written;

  int total = 0;
  int bad = 0;

  imem_loader #(.DEPTH(64), .ADDR_W(6), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Write-port log, sampled on the falling edge.
  int          nw = 0;
  int          cyc = 0;
  logic [5:0]  log_addr [0:511];
  logic [31:0] log_data [0:511];
  logic        log_rdy  [0:511];
  int          log_t    [0:511];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en && nw < 512) begin
      log_addr[nw] <= wr_addr;
      log_data[nw] <= wr_data;
      log_rdy[nw]  <= rx_ready;
      log_t[nw]    <= cyc;
      nw <= nw + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL send_byte: rx_ready=%b stuck for byte %h, required 1", rx_ready, b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rx_ready, wr_en, core_reset, done, error, err_code} !== 7'b0010000) begin
      bad++;
      $display("FAIL reset_ctl: got %b required 0010000",
               {rx_ready, wr_en, core_reset, done, error, err_code});
    end
    total++;
    if ({wr_addr, wr_data, words_written} !== 45'd0) begin
      bad++;
      $display("FAIL reset_data: addr=%h data=%h ww=%0d required 0", wr_addr, wr_data, words_written);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rx_ready, core_reset, done, error} !== 4'b0100) begin
      bad++;
      $display("FAIL idle_after_reset: got %b required 0100", {rx_ready, core_reset, done, error});
    end
  endtask

  task automatic test_two_words();
    int base = nw;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    // XOR of the eight data bytes is 0x89
    send_byte(8'h89);
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if (nw - base !== 2) begin
      bad++; $display("FAIL two_words_count: got %0d writes required 2", nw - base);
    end else begin
      total++;
      if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h20080005) begin
        bad++; $display("FAIL two_words_w0: addr=%0d data=%h required 0/20080005", log_addr[base], log_data[base]);
      end
      total++;
      if (log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'hAC080000) begin
        bad++; $display("FAIL two_words_w1: addr=%0d data=%h required 1/ac080000", log_addr[base+1], log_data[base+1]);
      end
    end
    total++;
    if ({done, core_reset, error, words_written} !== {3'b100, 7'd2}) begin
      bad++; $display("FAIL two_words_status: done=%b core_reset=%b error=%b ww=%0d required 1/0/0/2",
                      done, core_reset, error, words_written);
    end
  endtask

  task automatic test_bad_count();
    int base = nw;
    // Restart from DONE: core_reset must be high again once HDR is entered.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({rx_ready, core_reset, done, error} !== 4'b1100) begin
      bad++; $display("FAIL restart_hdr: rdy/crst/done/err=%b required 1100", {rx_ready, core_reset, done, error});
    end
    send_byte(8'h00);
    rx_valid = 1'b0;
    total++;
    if ({error, err_code, core_reset, done} !== 5'b10110) begin
      bad++; $display("FAIL hdr_zero: err/code/crst/done=%b required 10110", {error, err_code, core_reset, done});
    end
    pulse_start();
    total++;
    if ({error, err_code} !== 3'b000) begin
      bad++; $display("FAIL err_clear_on_start: err/code=%b required 000", {error, err_code});
    end
    send_byte(8'h41);
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({error, err_code, core_reset} !== 4'b1011 || nw != base) begin
      bad++; $display("FAIL hdr_over_depth: err/code/crst=%b writes=%0d required 1011 and 0",
                      {error, err_code, core_reset}, nw - base);
    end
  endtask

  task automatic test_bad_checksum();
    int base = nw;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if (nw - base !== 1 || log_addr[base] !== 6'd0 || log_data[base] !== 32'h12345678) begin
      bad++; $display("FAIL csum_word: writes=%0d addr=%0d data=%h required 1/0/12345678",
                      nw - base, log_addr[base], log_data[base]);
    end
    total++;
    if ({error, err_code, done, core_reset} !== 5'b11001) begin
      bad++; $display("FAIL csum_err: err/code/done/crst=%b required 11001", {error, err_code, done, core_reset});
    end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    rx_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (error) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL timeout_early: error=1 before 16 idle cycles, required 0");
    end
    @(negedge clk);
    total++;
    if ({error, err_code, core_reset} !== 4'b1111) begin
      bad++; $display("FAIL timeout_err: err/code/crst=%b required 1111", {error, err_code, core_reset});
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] fr [0:13];
    fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({rx_ready, wr_en, core_reset, done, error, err_code} !== 7'b0010000 ||
        {wr_addr, wr_data, words_written} !== 45'd0) begin
      bad++; $display("FAIL async_reset: ctl=%b addr=%h data=%h ww=%0d required 0010000 and zeros",
                      {rx_ready, wr_en, core_reset, done, error, err_code}, wr_addr, wr_data, words_written);
    end
    @(negedge clk);
    reset = 1'b0;
    base = nw;
    pulse_start();
    for (int i = 0; i < 14; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if (nw - base !== 3) begin
      bad++; $display("FAIL reload_count: got %0d writes required 3", nw - base);
    end else begin
      total++;
      if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h11223344 ||
          log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'h55667788 ||
          log_addr[base+2] !== 6'd2 || log_data[base+2] !== 32'h99AABBCC) begin
        bad++; $display("FAIL reload_words: %0d:%h %0d:%h %0d:%h required 0:11223344 1:55667788 2:99aabbcc",
                        log_addr[base], log_data[base], log_addr[base+1], log_data[base+1],
                        log_addr[base+2], log_data[base+2]);
      end
    end
    total++;
    if ({done, core_reset, words_written} !== {2'b10, 7'd3}) begin
      bad++; $display("FAIL reload_status: done=%b crst=%b ww=%0d required 1/0/3", done, core_reset, words_written);
    end
  endtask

  task automatic test_back_to_back();
    int base = nw;
    logic [7:0] b;
    pulse_start();
    send_byte(8'd64);
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * k + j);
        if (k * 4 + j == 10 || k * 4 + j == 101) start = 1'b1;
        send_byte(b);
        start = 1'b0;
      end
    end
    // XOR of bytes 0..255 is zero
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if (nw - base !== 64) begin
      bad++; $display("FAIL full_count: got %0d writes required 64", nw - base);
    end else begin
      for (int k = 0; k < 64; k++) begin
        total++;
        if (log_addr[base+k] !== 6'(k) ||
            log_data[base+k] !== {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)} ||
            log_rdy[base+k] !== 1'b0) begin
          bad++; $display("FAIL full_word%0d: addr=%0d data=%h rdy=%b", k,
                          log_addr[base+k], log_data[base+k], log_rdy[base+k]);
        end
        if (k > 0) begin
          total++;
          if (log_t[base+k] - log_t[base+k-1] !== 5) begin
            bad++; $display("FAIL full_spacing%0d: got %0d cycles required 5", k,
                            log_t[base+k] - log_t[base+k-1]);
          end
        end
      end
    end
    total++;
    if ({done, core_reset, error, words_written} !== {3'b100, 7'd64}) begin
      bad++; $display("FAIL full_status: done=%b crst=%b err=%b ww=%0d required 1/0/0/64",
                      done, core_reset, error, words_written);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_bad_count();
    test_bad_checksum();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
